mdu: RTL and testbench

- EX-stage multiply/divide unit that owns the HI/LO architectural registers.
- Executes mult, multu, div and divu with a fixed multi-cycle latency, and handles mthi/mtlo writes.
- Drives busy. The ID-stage hazard logic ORs busy with this unit's start input to stall HI/LO-class instructions.
- mfhi/mflo read hi/lo combinationally through the EX result mux.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_calc.sv | 66 ++++++
 rtl/mdu.sv | 100 ++++++++++
 tb/tb_mdu.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op encodings, default
// latencies and FSM state encoding.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_t;

    // Ops 0..3 are the multi-cycle arithmetic ops; bit 2 clear identifies them.
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath for mult/multu/div/divu; produces the full
// {hi,lo} result in one evaluation and flags division by zero.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] b_safe;
    logic        [31:0] bmag_safe;
    logic        [31:0] q_mag;
    logic        [31:0] r_mag;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 never overflows;
    // negating the magnitude 0x80000000 wraps back to 0x80000000 as required.
    assign a_mag     = a[31] ? (32'd0 - a) : a;
    assign b_mag     = b[31] ? (32'd0 - b) : b;
    assign b_safe    = (b == 32'd0) ? 32'd1 : b;
    assign bmag_safe = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag     = a_mag / bmag_safe;
    assign r_mag     = a_mag % bmag_safe;
    assign q_u       = a / b_safe;
    assign r_u       = a % b_safe;

    always_comb begin
        hi_res   = 32'd0;
        lo_res   = 32'd0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MDU_DIV: begin
                div_zero = (b == 32'd0);
                lo_res   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
                hi_res   = a[31] ? (32'd0 - r_mag) : r_mag;
            end
            MDU_DIVU: begin
                div_zero = (b == 32'd0);
                lo_res   = q_u;
                hi_res   = r_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs a fixed-latency busy
// window per op and commits the latched result when the window closes.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic        wr_en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_t state;
    mdu_state_t state_next;

    logic [CNT_W-1:0] count;
    logic [31:0]      temp_hi;
    logic [31:0]      temp_lo;
    logic             temp_dz;
    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             div_zero;
    logic             accept;

    mdu_calc u_calc (
        .op       (mdu_op),
        .a        (a),
        .b        (b),
        .hi_res   (hi_res),
        .lo_res   (lo_res),
        .div_zero (div_zero)
    );

    assign accept = (state == IDLE) && start && is_arith(mdu_op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Result is captured at the accept edge; HI/LO only move on completion
    // (skipped for divide-by-zero) or on an idle mthi/mtlo with no start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            temp_hi <= 32'd0;
            temp_lo <= 32'd0;
            temp_dz <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (state == IDLE) begin
            if (accept) begin
                temp_hi <= hi_res;
                temp_lo <= lo_res;
                temp_dz <= div_zero;
                count   <= mdu_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            end else if (wr_en && !start) begin
                if (mdu_op == MDU_MTHI) hi <= a;
                if (mdu_op == MDU_MTLO) lo <= a;
            end
        end else begin
            if (count == '0) begin
                if (!temp_dz) begin
                    hi <= temp_hi;
                    lo <= temp_lo;
                end
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops
// compared against a plain-arithmetic HI/LO model.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic        wr_en;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .wr_en  (wr_en),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of one op on HI/LO.
    function automatic void model_exec(input logic [2:0] op, input logic [31:0] x,
                                       input logic [31:0] y);
        longint          sx, sy, q, r, ps;
        longint unsigned ux, uy, pu;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (op)
            3'd0: begin ps = sx * sy; m_hi = ps[63:32]; m_lo = ps[31:0]; end
            3'd1: begin pu = ux * uy; m_hi = pu[63:32]; m_lo = pu[31:0]; end
            3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
            3'd3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endfunction

    function automatic int expected_cycles(input logic [2:0] op);
        return (op >= 3'd2) ? 10 : 5;
    endfunction

    // Issue one start pulse and measure the busy window; reports whether
    // hi/lo moved before the window closed.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                            output int cycles, output bit early);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        cycles = 0;
        early = 1'b0;
        start = 1'b1; mdu_op = op; a = x; b = y;
        tick();
        start = 1'b0; mdu_op = 3'd7; a = $urandom; b = $urandom;
        while (busy === 1'b1 && cycles < 50) begin
            cycles++;
            if (hi !== h0 || lo !== l0) early = 1'b1;
            tick();
        end
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [31:0] x);
        wr_en = 1'b1; mdu_op = op; a = x;
        tick();
        wr_en = 1'b0; mdu_op = 3'd7;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; wr_en = 1'b0; mdu_op = 3'd7; a = '0; b = '0;
        #23;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_state busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        tick();
    endtask

    task automatic test_mult;
        int cyc; bit early;
        issue_op(3'd0, 32'hFFFFFFFD, 32'd5, cyc, early);
        total++;
        if (cyc !== 5 || early) begin
            bad++;
            $display("[TB] FAIL mult_busy cycles=%0d early=%0b required 5/0", cyc, early);
        end
        total++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
            bad++;
            $display("[TB] FAIL mult_result hi=%h lo=%h required ffffffff/fffffff1", hi, lo);
        end
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFF1;
    endtask

    task automatic test_div;
        int cyc; bit early;
        issue_op(3'd3, 32'd7, 32'd2, cyc, early);
        total++;
        if (cyc !== 10 || hi !== 32'd1 || lo !== 32'd3) begin
            bad++;
            $display("[TB] FAIL divu_7_2 cycles=%0d hi=%h lo=%h required 10/1/3", cyc, hi, lo);
        end
        issue_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc, early);
        total++;
        if (cyc !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            bad++;
            $display("[TB] FAIL div_m7_2 cycles=%0d hi=%h lo=%h required 10/ffffffff/fffffffd", cyc, hi, lo);
        end
        issue_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc, early);
        total++;
        if (hi !== 32'd0 || lo !== 32'h80000000) begin
            bad++;
            $display("[TB] FAIL div_overflow hi=%h lo=%h required 0/80000000", hi, lo);
        end
        m_hi = 32'd0; m_lo = 32'h80000000;
    endtask

    task automatic test_mthi_mtlo;
        wr_en = 1'b1; mdu_op = 3'd4; a = 32'h12345678;
        tick();
        total++;
        if (hi !== 32'h12345678 || lo !== m_lo || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mthi hi=%h lo=%h busy=%0b required 12345678/%h/0", hi, lo, busy, m_lo);
        end
        mdu_op = 3'd5; a = 32'h9ABCDEF0;
        tick();
        wr_en = 1'b0; mdu_op = 3'd7;
        total++;
        if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mtlo hi=%h lo=%h busy=%0b required 12345678/9abcdef0/0", hi, lo, busy);
        end
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    endtask

    task automatic test_div_zero;
        int cyc; bit early;
        write_reg(3'd4, 32'hAA);
        write_reg(3'd5, 32'hBB);
        issue_op(3'd2, 32'd1234, 32'd0, cyc, early);
        total++;
        if (cyc !== 10 || hi !== 32'hAA || lo !== 32'hBB) begin
            bad++;
            $display("[TB] FAIL div_zero cycles=%0d hi=%h lo=%h required 10/aa/bb", cyc, hi, lo);
        end
        issue_op(3'd3, 32'd99, 32'd0, cyc, early);
        total++;
        if (cyc !== 10 || hi !== 32'hAA || lo !== 32'hBB) begin
            bad++;
            $display("[TB] FAIL divu_zero cycles=%0d hi=%h lo=%h required 10/aa/bb", cyc, hi, lo);
        end
        m_hi = 32'hAA; m_lo = 32'hBB;
    endtask

    task automatic test_overlap;
        int cyc;
        start = 1'b1; mdu_op = 3'd1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        tick();
        start = 1'b0; mdu_op = 3'd7;
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            cyc++;
            start = (cyc == 2); wr_en = (cyc == 3);
            mdu_op = (cyc == 2) ? 3'd0 : ((cyc == 3) ? 3'd4 : 3'd7);
            a = 32'h0000DEAD; b = 32'd3;
            tick();
            start = 1'b0; wr_en = 1'b0;
        end
        total++;
        if (cyc !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++;
            $display("[TB] FAIL overlap cycles=%0d hi=%h lo=%h required 5/fffffffe/00000001", cyc, hi, lo);
        end
        // Illegal op with start must leave everything alone.
        start = 1'b1; mdu_op = 3'd6; a = 32'h5; b = 32'h6;
        tick();
        start = 1'b0; mdu_op = 3'd7;
        total++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            bad++;
            $display("[TB] FAIL start_illegal_op busy=%0b hi=%h lo=%h required 0/fffffffe/00000001", busy, hi, lo);
        end
        // start and wr_en together: multiply wins, mthi dropped.
        start = 1'b1; wr_en = 1'b1; mdu_op = 3'd1; a = 32'd3; b = 32'd4;
        tick();
        start = 1'b0; wr_en = 1'b0; mdu_op = 3'd7;
        total++;
        if (busy !== 1'b1 || hi !== 32'hFFFFFFFE) begin
            bad++;
            $display("[TB] FAIL start_wr_same busy=%0b hi=%h required 1/fffffffe", busy, hi);
        end
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin cyc++; tick(); end
        total++;
        if (cyc !== 5 || hi !== 32'd0 || lo !== 32'd12) begin
            bad++;
            $display("[TB] FAIL start_wr_result cycles=%0d hi=%h lo=%h required 5/0/c", cyc, hi, lo);
        end
        m_hi = 32'd0; m_lo = 32'd12;
    endtask

    task automatic test_reset_mid;
        write_reg(3'd4, 32'h11111111);
        write_reg(3'd5, 32'h22222222);
        start = 1'b1; mdu_op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0; mdu_op = 3'd7;
        tick(); tick(); tick();
        #3;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_op busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        #2;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_no_commit busy=%0b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_random;
        int cyc; bit early;
        logic [2:0]  op;
        logic [31:0] x, y;
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                op = 3'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0:       y = 32'd0;
                    1, 2:    y = $urandom_range(1, 100);
                    3:       y = 32'd0 - 32'($urandom_range(1, 100));
                    default: y = $urandom;
                endcase
                if (i == 5) begin x = 32'h80000000; y = 32'hFFFFFFFF; op = 3'd2; end
                issue_op(op, x, y, cyc, early);
                model_exec(op, x, y);
                total++;
                if (cyc !== expected_cycles(op) || early || hi !== m_hi || lo !== m_lo) begin
                    bad++;
                    $display("[TB] FAIL random_arith i=%0d op=%0d a=%h b=%h cycles=%0d early=%0b hi=%h lo=%h required %0d/0/%h/%h",
                             i, op, x, y, cyc, early, hi, lo, expected_cycles(op), m_hi, m_lo);
                end
            end else begin
                op = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
                write_reg(op, x);
                model_exec(op, x, 32'd0);
                total++;
                if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                    bad++;
                    $display("[TB] FAIL random_write i=%0d op=%0d busy=%0b hi=%h lo=%h required 0/%h/%h",
                             i, op, busy, hi, lo, m_hi, m_lo);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_div_zero();
        test_overlap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
